pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control block that drives the `pc_en` and `PCSrc` inputs of the program counter.
- Arbitrates between four things:
  - sequential fetch;
  - taken branch (resolved in EX), jump (J/JAL, decoded in ID) and jump-register (JR, decoded in ID);
  - memory and load-use stalls;
  - halt.
- Generates the pipeline flush strobes that accompany each redirect.
- Holds a redirect across instruction-memory wait cycles, so a redirect is never lost when `ihit` is low.
- Sits between hazard/branch logic and the PC register; the PC register consumes `pc_en`/`PCSrc` in the same cycle.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction memory returned fetch this cycle.
- dhit  in  1  data memory access completed this cycle.
- dmem_req  in  1  MEM stage holds a load/store awaiting `dhit`.
- load_use  in  1  ID instruction depends on a load in EX; hold fetch.
- branch_taken  in  1  EX resolved a taken branch.
- jump  in  1  ID holds J/JAL.
- jr  in  1  ID holds JR.
- halt  in  1  HALT instruction reached commit.
- pc_en  out  1  PC register load enable.
- PCSrc  out  3  next-PC select, encoded as `pcsrc_t`.
- flush_ifid  out  1  clear IF/ID latch this cycle.
- flush_idex  out  1  clear ID/EX latch this cycle.
- halted  out  1  sequencer is in HALTED.
- stall_cnt  out  CNT_W  cycles with `pc_en`=0 since reset, saturating.

Behaviour:
- PCSrc encoding (`pcsrc_t`): SEQ=0 (PC+4), BR=1 (branch target), JMP=2 (`immediate26`), JR=3 (`rdat1`); values 4-7 reserved, never driven.
- State machine: RUN, MEMWAIT, REDIRECT, HALTED. All state updates are on the rising edge of CLK.
- Outputs are Mealy: a function of current state and current inputs, with zero-cycle latency.
- Reset (RST=1 at an edge):
  - state=RUN, pend_src=SEQ, stall_cnt=0.
  - During and after reset until the first non-reset edge, the outputs follow RUN with all inputs ignored: pc_en=0, PCSrc=SEQ, flushes=0, halted=0.
  - Reset mid-redirect or mid-MEMWAIT discards the pending redirect.
- Redirect request priority, highest first: branch_taken > jr > jump.
  - A branch is older than the ID instruction, so it wins.
  - jump and jr are ignored when load_use=1, because the ID instruction is stalled.
- RUN, evaluated in order:
  1. halt=1: pc_en=0, no flush, next state HALTED.
  2. dmem_req=1 and dhit=0: pc_en=0, PCSrc=SEQ, no flush, next state MEMWAIT.
     - A redirect arriving this cycle is latched into pend_src and replayed after MEMWAIT.
  3. Redirect requested:
     - PCSrc = selected source; pc_en = ihit.
     - flush_ifid=1 for any redirect; flush_idex=1 additionally for branch_taken only. Flushes are asserted only in the cycle pc_en=1.
     - If ihit=0: latch pend_src and go to REDIRECT.
  4. load_use=1: pc_en=0, PCSrc=SEQ.
  5. Otherwise: PCSrc=SEQ, pc_en=ihit.
- MEMWAIT:
  - pc_en=0 until dhit=1.
  - On dhit=1, next state is REDIRECT if pend_src≠SEQ, else RUN. The PC does not advance in the dhit cycle.
  - New redirect inputs are ignored, because the pipeline is frozen.
- REDIRECT:
  - PCSrc=pend_src; pc_en=ihit; flushes as in RUN step 3, keyed on pend_src.
  - On ihit=1: clear pend_src and return to RUN.
  - halt=1 overrides and goes to HALTED.
- Upstream requirement: branch target, `immediate26` and `rdat1` are held stable by the stalled pipeline while in MEMWAIT/REDIRECT. The sequencer stores only the source select, not the address.
- HALTED: pc_en=0, PCSrc=SEQ, flushes=0, halted=1. Exit only by reset.
- stall_cnt:
  - Increments on every non-reset cycle with pc_en=0 and state≠HALTED.
  - Saturates at 2^CNT_W−1 with no wrap.

Decomposition:
- Shared package (`cpu_types_pkg`): the `pcsrc_t` enum (SEQ/BR/JMP/JR) and the sequencer state enum. The PC block and this block decode PCSrc from the same definition.
- One natural sub-module: `sat_counter`, parameterised by CNT_W with inc/clear inputs, for stall_cnt.

Test Plan:
- Reset then ihit=1 every cycle, no other inputs -> pc_en=1, PCSrc=0, flushes 0, stall_cnt stays 0.
- branch_taken=1 and jump=1 in the same cycle, ihit=1 -> PCSrc=1, pc_en=1, flush_ifid=1, flush_idex=1 for exactly one cycle.
- jr=1 with ihit=0 for 3 cycles, then ihit=1 -> state REDIRECT; PCSrc=3 throughout; pc_en=1 only on the 4th cycle; stall_cnt=3.
- dmem_req=1 with dhit=0 for 4 cycles while branch_taken=1 in cycle 1, then dhit=1, then ihit=1 -> PCSrc=1 with flushes on the first ihit cycle after dhit; no PC update during MEMWAIT.
- halt=1 during RUN, then 10 cycles of ihit=1, then RST=1 -> halted=1 and pc_en=0 for all 10 cycles; after reset halted=0 and stall_cnt=0.
- CNT_W=4, hold load_use=1 for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared by the PC register and the PC sequencer: next-PC source select
// and the sequencer state encoding.
package cpu_types_pkg;

    typedef enum logic [2:0] {
        SEQ = 3'd0,
        BR  = 3'd1,
        JMP = 3'd2,
        JR  = 3'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } seq_state_t;

    // Only a taken branch is old enough to have a wrong-path instruction in ID/EX.
    function automatic logic src_flushes_idex(input pcsrc_t src);
        return (src == BR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: arbitrates fetch, redirects, stalls and halt into pc_en/PCSrc,
// holding a redirect source across instruction-memory and data-memory waits.
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jr,
    input  logic             halt,
    output logic             pc_en,
    output logic [2:0]       PCSrc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    seq_state_t state_q, state_d;
    pcsrc_t     pend_q, pend_d;
    pcsrc_t     req_src;
    pcsrc_t     src_d;
    logic       pc_en_d;
    logic       fl_ifid_d;
    logic       fl_idex_d;
    logic       stall_inc;

    // A stalled ID instruction cannot issue its jump, but an EX branch still can.
    always_comb begin
        req_src = SEQ;
        if (branch_taken) begin
            req_src = BR;
        end else if (!load_use && jr) begin
            req_src = JR;
        end else if (!load_use && jump) begin
            req_src = JMP;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pc_en_d   = 1'b0;
        src_d     = SEQ;
        fl_ifid_d = 1'b0;
        fl_idex_d = 1'b0;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (dmem_req && !dhit) begin
                    state_d = MEMWAIT;
                    pend_d  = req_src;
                end else if (req_src != SEQ) begin
                    src_d     = req_src;
                    pc_en_d   = ihit;
                    fl_ifid_d = ihit;
                    fl_idex_d = ihit && src_flushes_idex(req_src);
                    if (!ihit) begin
                        state_d = REDIRECT;
                        pend_d  = req_src;
                    end
                end else if (!load_use) begin
                    pc_en_d = ihit;
                end
            end
            MEMWAIT: begin
                if (dhit) begin
                    state_d = (pend_q != SEQ) ? REDIRECT : RUN;
                end
            end
            REDIRECT: begin
                if (halt) begin
                    state_d = HALTED;
                    pend_d  = SEQ;
                end else begin
                    src_d     = pend_q;
                    pc_en_d   = ihit;
                    fl_ifid_d = ihit;
                    fl_idex_d = ihit && src_flushes_idex(pend_q);
                    if (ihit) begin
                        state_d = RUN;
                        pend_d  = SEQ;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                pend_d  = SEQ;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pend_q  <= SEQ;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs are Mealy; while RST is high they show an idle RUN regardless of inputs.
    assign pc_en      = !RST && pc_en_d;
    assign PCSrc      = RST ? SEQ : src_d;
    assign flush_ifid = !RST && fl_ifid_d;
    assign flush_idex = !RST && fl_idex_d;
    assign halted     = !RST && (state_q == HALTED);

    assign stall_inc = !pc_en_d && (state_q != HALTED);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i  (CLK),
        .clear_i(RST),
        .inc_i  (stall_inc),
        .count_o(stall_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// behavioural model built from pending-redirect / memory-wait / halted flags.
module tb_pc_sequencer;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, dmem_req, load_use, branch_taken, jump, jr, halt;
    logic             pc_en;
    logic [2:0]       PCSrc;
    logic             flush_ifid, flush_idex, halted;
    logic [CNT_W-1:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;

    // Model state: halted, frozen on data memory, redirect still owed (0 = none).
    bit m_halted  = 1'b0;
    bit m_memwait = 1'b0;
    int m_pend    = 0;
    int m_cnt     = 0;
    int m_req     = 0;

    logic       e_pc_en, e_fi, e_fx, e_halted;
    logic [2:0] e_src;
    int         e_cnt;

    pc_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmem_req    (dmem_req),
        .load_use    (load_use),
        .branch_taken(branch_taken),
        .jump        (jump),
        .jr          (jr),
        .halt        (halt),
        .pc_en       (pc_en),
        .PCSrc       (PCSrc),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic set_in(input bit r, input bit ih, input bit dh, input bit dreq,
                          input bit lu, input bit br, input bit jp, input bit jrr,
                          input bit hl);
        RST = r; ihit = ih; dhit = dh; dmem_req = dreq; load_use = lu;
        branch_taken = br; jump = jp; jr = jrr; halt = hl;
    endtask

    task automatic predict();
        @(negedge CLK);
        m_req = branch_taken ? 1 : (!load_use && jr) ? 3 : (!load_use && jump) ? 2 : 0;
        e_pc_en = 0; e_src = 0; e_fi = 0; e_fx = 0; e_halted = 0; e_cnt = m_cnt;
        if (RST) begin
            e_halted = 0;
        end else if (m_halted) begin
            e_halted = 1;
        end else if (m_memwait) begin
            e_pc_en = 0;
        end else if (m_pend != 0) begin
            if (!halt) begin
                e_src = 3'(m_pend); e_pc_en = ihit; e_fi = ihit; e_fx = ihit && (m_pend == 1);
            end
        end else if (halt || (dmem_req && !dhit)) begin
            e_pc_en = 0;
        end else if (m_req != 0) begin
            e_src = 3'(m_req); e_pc_en = ihit; e_fi = ihit; e_fx = ihit && (m_req == 1);
        end else begin
            e_pc_en = ihit && !load_use;
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        if (RST) begin
            m_halted = 0; m_memwait = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (!e_pc_en && !m_halted && m_cnt < CNT_MAX) m_cnt++;
            if (m_halted) begin
                m_halted = 1;
            end else if (m_memwait) begin
                if (dhit) m_memwait = 0;
            end else if (m_pend != 0) begin
                if (halt) begin
                    m_halted = 1; m_pend = 0;
                end else if (ihit) begin
                    m_pend = 0;
                end
            end else if (halt) begin
                m_halted = 1;
            end else if (dmem_req && !dhit) begin
                m_memwait = 1; m_pend = m_req;
            end else if (m_req != 0 && !ihit) begin
                m_pend = m_req;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        predict();
        advance();
    endtask

    task automatic test_reset();
        set_in(1, 1, 1, 1, 1, 1, 1, 1, 1);
        predict();
        advance();
        set_in(1, 1, 0, 1, 0, 1, 0, 1, 0);
        predict();
        nvec++;
        if ({pc_en, PCSrc, flush_ifid, flush_idex, halted, stall_cnt} !== {4'b0000, 3'b000, {CNT_W{1'b0}}}) begin
            nerr++;
            $display("FAIL reset_outputs: got pc_en=%b src=%0d fi=%b fx=%b halted=%b cnt=%0d, want all zero",
                     pc_en, PCSrc, flush_ifid, flush_idex, halted, stall_cnt);
        end
        advance();
    endtask

    task automatic test_seq_fetch();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
            predict();
            nvec++;
            if ({pc_en, PCSrc, flush_ifid, flush_idex, stall_cnt} !== {1'b1, 3'd0, 2'b00, {CNT_W{1'b0}}}) begin
                nerr++;
                $display("FAIL seq_fetch cyc %0d: got pc_en=%b src=%0d fi=%b fx=%b cnt=%0d, want 1 0 0 0 0",
                         i, pc_en, PCSrc, flush_ifid, flush_idex, stall_cnt);
            end
            advance();
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(0, 1, 0, 0, 0, 1, 1, 0, 0);
        predict();
        nvec++;
        if ({pc_en, PCSrc, flush_ifid, flush_idex} !== {1'b1, 3'd1, 2'b11}) begin
            nerr++;
            $display("FAIL branch_over_jump: got pc_en=%b src=%0d fi=%b fx=%b, want 1 1 1 1",
                     pc_en, PCSrc, flush_ifid, flush_idex);
        end
        advance();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        predict();
        nvec++;
        if ({pc_en, PCSrc, flush_ifid, flush_idex} !== {1'b1, 3'd0, 2'b00}) begin
            nerr++;
            $display("FAIL branch_flush_one_cycle: got pc_en=%b src=%0d fi=%b fx=%b, want 1 0 0 0",
                     pc_en, PCSrc, flush_ifid, flush_idex);
        end
        advance();
    endtask

    task automatic test_jr_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, (i == 3), 0, 0, 0, 0, 0, (i < 3), 0);
            predict();
            nvec++;
            if ({pc_en, PCSrc, flush_ifid, flush_idex} !== {(i == 3), 3'd3, (i == 3), 1'b0}) begin
                nerr++;
                $display("FAIL jr_wait cyc %0d: got pc_en=%b src=%0d fi=%b fx=%b, want %b 3 %b 0",
                         i, pc_en, PCSrc, flush_ifid, flush_idex, (i == 3), (i == 3));
            end
            advance();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        predict();
        nvec++;
        if (stall_cnt !== CNT_W'(3)) begin
            nerr++;
            $display("FAIL jr_wait_stall_cnt: got %0d, want 3", stall_cnt);
        end
        advance();
    endtask

    task automatic test_memwait_branch();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, (i == 4), (i < 5), 0, (i == 0), 0, 0, 0);
            predict();
            nvec++;
            if (i < 5 && pc_en !== 1'b0) begin
                nerr++;
                $display("FAIL memwait_hold cyc %0d: got pc_en=%b, want 0", i, pc_en);
            end else if (i == 5 && {pc_en, PCSrc, flush_ifid, flush_idex} !== {1'b1, 3'd1, 2'b11}) begin
                nerr++;
                $display("FAIL memwait_replay: got pc_en=%b src=%0d fi=%b fx=%b, want 1 1 1 1",
                         pc_en, PCSrc, flush_ifid, flush_idex);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 1);
        predict();
        advance();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
            predict();
            nvec++;
            if ({halted, pc_en} !== 2'b10) begin
                nerr++;
                $display("FAIL halted_hold cyc %0d: got halted=%b pc_en=%b, want 1 0", i, halted, pc_en);
            end
            advance();
        end
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        predict();
        nvec++;
        if ({halted, stall_cnt} !== {1'b0, {CNT_W{1'b0}}}) begin
            nerr++;
            $display("FAIL halt_reset: got halted=%b cnt=%0d, want 0 0", halted, stall_cnt);
        end
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 0, 0, 0);
            predict();
            advance();
        end
        set_in(0, 1, 0, 0, 1, 0, 0, 0, 0);
        predict();
        nvec++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin
            nerr++;
            $display("FAIL stall_saturate: got %0d, want %0d", stall_cnt, CNT_MAX);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 79) == 0));
            predict();
            nvec++;
            if ({pc_en, PCSrc, flush_ifid, flush_idex, halted, stall_cnt} !==
                {e_pc_en, e_src, e_fi, e_fx, e_halted, CNT_W'(e_cnt)}) begin
                nerr++;
                $display("FAIL random cyc %0d: got pc_en=%b src=%0d fi=%b fx=%b h=%b cnt=%0d, want %b %0d %b %b %b %0d",
                         i, pc_en, PCSrc, flush_ifid, flush_idex, halted, stall_cnt,
                         e_pc_en, e_src, e_fi, e_fx, e_halted, e_cnt);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_branch_priority();
        test_jr_wait();
        test_memwait_branch();
        test_halt();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
